// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and helpers
// for the single-clock programmable FIFO.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD,
    FIFO_FWFT
  } fifo_rd_mode_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit thresh_ok(
    input int depth,
    input int af,
    input int ae
  );
    return (depth >= 2) &&
           (af >= 1) && (af <= depth) &&
           (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/ram_simple_dual_port.sv
// ram_simple_dual_port: one write port,
// one registered read port; contents not reset.
module ram_simple_dual_port #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             WR_CLK,
  input  logic             WR_EN,
  input  logic [AW-1:0]    WR_ADDR,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             RD_CLK,
  input  logic             RD_RST_N,
  input  logic             RD_EN,
  input  logic [AW-1:0]    RD_ADDR,
  output logic [WIDTH-1:0] RD_DATA
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge WR_CLK) begin
    if (WR_EN) mem[WR_ADDR] <= WR_DATA;
  end

  // only the output register is cleared
  always_ff @(posedge RD_CLK) begin
    if (!RD_RST_N) begin
      RD_DATA <= '0;
    end else if (RD_EN) begin
      RD_DATA <= mem[RD_ADDR];
    end
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO, any depth,
// programmable flags, standard or FWFT read.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter bit FWFT      = 1'b0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int CNT_W     = cnt_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             WR_ACK,
  output logic             OVERFLOW,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RD_VALID,
  output logic             UNDERFLOW,
  output logic             FULL,
  output logic             EMPTY,
  output logic             ALMOST_FULL,
  output logic             ALMOST_EMPTY,
  output logic [CNT_W-1:0] DATA_COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam fifo_rd_mode_e MODE =
    FWFT ? FIFO_FWFT : FIFO_STD;
  localparam logic [CNT_W-1:0] DEPTH_C =
    CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C =
    CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C =
    CNT_W'(AE_THRESH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH))
  begin : g_bad_thresh
    $error("sync_fifo_prog: illegal DEPTH/AF_THRESH/AE_THRESH");
  end

  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt, ram_cnt;
  logic             wr_acc, rd_acc, ram_we, ram_rd;
  logic             vld_nxt;
  logic             full_q, empty_q, af_q, ae_q;
  logic             ack_q, ovf_q, unf_q, vld_q;

  assign wr_acc = WR_EN & ~full_q;
  assign rd_acc = RD_EN & ~empty_q;
  assign ram_we = wr_acc & RST_N;

  // FWFT: vld_q marks the RAM output register as the head word
  always_comb begin
    count_nxt = count;
    ram_cnt   = count - CNT_W'(vld_q);
    ram_rd    = 1'b0;
    vld_nxt   = 1'b0;
    if (wr_acc && !rd_acc)
      count_nxt = count + CNT_W'(1);
    else if (!wr_acc && rd_acc)
      count_nxt = count - CNT_W'(1);
    unique case (MODE)
      FIFO_FWFT: begin
        ram_rd  = (ram_cnt != '0) &&
                  (!vld_q || rd_acc);
        vld_nxt = ram_rd || (vld_q && !rd_acc);
      end
      default: begin
        ram_rd  = rd_acc;
        vld_nxt = rd_acc;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (ram_rd) rd_ptr <= ptr_inc(rd_ptr);
      count   <= count_nxt;
      full_q  <= (count_nxt == DEPTH_C);
      empty_q <= (MODE == FIFO_FWFT) ?
                 !vld_nxt : (count_nxt == '0);
      af_q    <= (count_nxt >= AF_C);
      ae_q    <= (count_nxt <= AE_C);
      ack_q   <= wr_acc;
      ovf_q   <= WR_EN & full_q;
      unf_q   <= RD_EN & empty_q;
      vld_q   <= vld_nxt;
    end
  end

  ram_simple_dual_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .WR_CLK   (CLK),
    .WR_EN    (ram_we),
    .WR_ADDR  (wr_ptr),
    .WR_DATA  (WR_DATA),
    .RD_CLK   (CLK),
    .RD_RST_N (RST_N),
    .RD_EN    (ram_rd),
    .RD_ADDR  (rd_ptr),
    .RD_DATA  (RD_DATA)
  );

  assign WR_ACK       = ack_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;
  assign RD_VALID     = vld_q;
  assign FULL         = full_q;
  assign EMPTY        = empty_q;
  assign ALMOST_FULL  = af_q;
  assign ALMOST_EMPTY = ae_q;
  assign DATA_COUNT   = count;

endmodule
